voice_allocator_p: RTL and testbench

// Parametrised polyphonic voice table feeding the pipelined phase/wave/SVF chain.

---
 rtl/voice_allocator_p_pkg.sv | 17 +
 rtl/voice_allocator_p_oldest_voice_finder.sv | 29 ++
 rtl/voice_allocator_p.sv | 210 +++++++++++++++++++++
 tb/tb_voice_allocator_p.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_p_pkg.sv
// Shared command encoding for the voice allocator: command bit values, reserved notes and decoded ops.
package voice_allocator_p_pkg;

  localparam logic CMD_NOTE_ON  = 1'b1;
  localparam logic CMD_NOTE_OFF = 1'b0;
  localparam int   MIDI_OFF     = 0;    // note 0 marks an empty slot
  localparam int   WAVE_VEL     = 0;    // note-on with note 0 and this velocity is CHANGE_WAVE

  typedef enum logic [2:0] {
    OP_IDLE     = 3'd0,
    OP_NOTE_ON  = 3'd1,
    OP_NOTE_OFF = 3'd2,
    OP_STOP_ALL = 3'd3,
    OP_WAVE     = 3'd4
  } voice_op_e;

endpackage

// File: rtl/voice_allocator_p_oldest_voice_finder.sv
// Picks the steal victim: the slot with the largest age, lowest index on ties, plus a table-full flag.
module voice_allocator_p_oldest_voice_finder #(
  parameter  int NVOICES = 10,
  parameter  int AGE_W   = 6,
  localparam int IDX_W   = $clog2(NVOICES)
) (
  input  logic [NVOICES-1:0] occupied,
  input  logic [AGE_W-1:0]   ages [NVOICES],
  output logic               full,
  output logic [IDX_W-1:0]   victim
);

  logic [AGE_W-1:0] best_age_s;
  logic [IDX_W-1:0] best_idx_s;

  // Priority scan; strict greater-than keeps the lowest index on ties.
  always_comb begin
    best_age_s = ages[0];
    best_idx_s = IDX_W'(0);
    for (int i = 1; i < NVOICES; i++) begin
      best_idx_s = (ages[i] > best_age_s) ? IDX_W'(i) : best_idx_s;
      best_age_s = (ages[i] > best_age_s) ? ages[i]   : best_age_s;
    end
  end

  assign full   = &occupied;
  assign victim = best_idx_s;

endmodule

// File: rtl/voice_allocator_p.sv
// Polyphonic voice table: note command handling with oldest-voice stealing, and a round-robin slot dispatcher.
module voice_allocator_p
  import voice_allocator_p_pkg::*;
#(
  parameter  int NVOICES = 10,
  parameter  int MIDI_W  = 7,
  parameter  int VEL_W   = 8,
  parameter  int AGE_W   = 6,
  parameter  int NWAVES  = 4,
  localparam int IDX_W   = $clog2(NVOICES),
  localparam int CNT_W   = $clog2(NVOICES + 1),
  localparam int DATA_W  = 1 + MIDI_W + VEL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              i_cmd_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic [MIDI_W-1:0] o_midi,
  output logic [VEL_W-1:0]  o_velocity,
  output logic [IDX_W-1:0]  o_voice_idx,
  output logic              o_valid,
  output logic              o_frame,
  output logic [NWAVES-1:0] o_wave_sel,
  output logic [CNT_W-1:0]  o_active,
  output logic              o_steal
);

  localparam logic [MIDI_W-1:0] NOTE_EMPTY = MIDI_W'(MIDI_OFF);
  localparam logic [MIDI_W-1:0] NOTE_STOP  = {MIDI_W{1'b1}};
  localparam logic [AGE_W-1:0]  AGE_MAX    = {AGE_W{1'b1}};

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + AGE_W'(1);
  endfunction

  logic [MIDI_W-1:0] midi_r [NVOICES];
  logic [VEL_W-1:0]  vel_r  [NVOICES];
  logic [AGE_W-1:0]  age_r  [NVOICES];
  logic [MIDI_W-1:0] midi_s [NVOICES];
  logic [VEL_W-1:0]  vel_s  [NVOICES];
  logic [AGE_W-1:0]  age_s  [NVOICES];
  logic [IDX_W-1:0]  slot_r;

  logic              cmd_bit_s;
  logic [MIDI_W-1:0] cmd_midi_s;
  logic [VEL_W-1:0]  cmd_vel_s;
  voice_op_e         op_s;
  logic [NVOICES-1:0] occupied_s;
  logic              hit_s;
  logic [IDX_W-1:0]  hit_idx_s;
  logic              free_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic              full_s;
  logic [IDX_W-1:0]  victim_s;
  logic [IDX_W-1:0]  target_s;
  logic              steal_s;
  logic [CNT_W-1:0]  count_s;
  logic [NWAVES-1:0] wave_s;

  assign cmd_bit_s  = i_data[DATA_W-1];
  assign cmd_midi_s = i_data[DATA_W-2 -: MIDI_W];
  assign cmd_vel_s  = i_data[VEL_W-1:0];

  // Decode the incoming command into a single table operation.
  always_comb begin
    op_s = OP_IDLE;
    if (!i_cmd_valid) begin
      op_s = OP_IDLE;
    end else if (cmd_bit_s == CMD_NOTE_ON) begin
      if (cmd_midi_s != NOTE_EMPTY) begin
        op_s = OP_NOTE_ON;
      end else if (cmd_vel_s == VEL_W'(WAVE_VEL)) begin
        op_s = OP_WAVE;
      end else begin
        op_s = OP_IDLE;
      end
    end else begin
      if (cmd_midi_s == NOTE_STOP) begin
        op_s = OP_STOP_ALL;
      end else if (cmd_midi_s != NOTE_EMPTY) begin
        op_s = OP_NOTE_OFF;
      end else begin
        op_s = OP_IDLE;
      end
    end
  end

  // Lowest slot holding the command note and lowest empty slot; descending scan lets low indices win.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = IDX_W'(0);
    free_s     = 1'b0;
    free_idx_s = IDX_W'(0);
    for (int i = NVOICES - 1; i >= 0; i--) begin
      occupied_s[i] = (midi_r[i] != NOTE_EMPTY);
      hit_idx_s     = (midi_r[i] == cmd_midi_s) ? IDX_W'(i) : hit_idx_s;
      hit_s         = hit_s | (midi_r[i] == cmd_midi_s);
      free_idx_s    = (midi_r[i] == NOTE_EMPTY) ? IDX_W'(i) : free_idx_s;
      free_s        = free_s | (midi_r[i] == NOTE_EMPTY);
    end
  end

  voice_allocator_p_oldest_voice_finder #(
    .NVOICES (NVOICES),
    .AGE_W   (AGE_W)
  ) u_oldest (
    .occupied (occupied_s),
    .ages     (age_r),
    .full     (full_s),
    .victim   (victim_s)
  );

  assign target_s = hit_s ? hit_idx_s : (free_s ? free_idx_s : victim_s);
  assign steal_s  = (op_s == OP_NOTE_ON) && !hit_s && full_s;

  // Next table contents, occupancy count and waveform select.
  always_comb begin
    midi_s = midi_r;
    vel_s  = vel_r;
    age_s  = age_r;
    wave_s = o_wave_sel;
    case (op_s)
      OP_NOTE_ON: begin
        for (int i = 0; i < NVOICES; i++) begin
          if (IDX_W'(i) == target_s) begin
            midi_s[i] = cmd_midi_s;
            vel_s[i]  = cmd_vel_s;
            age_s[i]  = AGE_W'(0);
          end else if (occupied_s[i]) begin
            age_s[i]  = age_inc(age_r[i]);
          end else begin
            age_s[i]  = age_r[i];
          end
        end
      end
      OP_NOTE_OFF: begin
        for (int i = 0; i < NVOICES; i++) begin
          if (hit_s && (IDX_W'(i) == hit_idx_s)) begin
            midi_s[i] = NOTE_EMPTY;
            vel_s[i]  = VEL_W'(0);
            age_s[i]  = AGE_W'(0);
          end else begin
            midi_s[i] = midi_r[i];
          end
        end
      end
      OP_STOP_ALL: begin
        for (int i = 0; i < NVOICES; i++) begin
          midi_s[i] = NOTE_EMPTY;
          vel_s[i]  = VEL_W'(0);
          age_s[i]  = AGE_W'(0);
        end
      end
      OP_WAVE: begin
        wave_s = {o_wave_sel[NWAVES-2:0], o_wave_sel[NWAVES-1]};
      end
      default: begin
        wave_s = o_wave_sel;
      end
    endcase
    count_s = CNT_W'(0);
    for (int i = 0; i < NVOICES; i++) begin
      count_s = count_s + CNT_W'(midi_s[i] != NOTE_EMPTY);
    end
  end

  // Voice table and command-side status registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NVOICES; i++) begin
        midi_r[i] <= NOTE_EMPTY;
        vel_r[i]  <= VEL_W'(0);
        age_r[i]  <= AGE_W'(0);
      end
      o_active   <= CNT_W'(0);
      o_steal    <= 1'b0;
      o_wave_sel <= NWAVES'(1);
    end else begin
      midi_r     <= midi_s;
      vel_r      <= vel_s;
      age_r      <= age_s;
      o_active   <= count_s;
      o_steal    <= steal_s;
      o_wave_sel <= wave_s;
    end
  end

  // Round-robin dispatch of the pre-update table entry on each clk_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_r      <= IDX_W'(0);
      o_midi      <= NOTE_EMPTY;
      o_velocity  <= VEL_W'(0);
      o_voice_idx <= IDX_W'(0);
      o_valid     <= 1'b0;
      o_frame     <= 1'b0;
    end else if (clk_en) begin
      o_midi      <= midi_r[slot_r];
      o_velocity  <= vel_r[slot_r];
      o_voice_idx <= slot_r;
      o_valid     <= (midi_r[slot_r] != NOTE_EMPTY);
      o_frame     <= (slot_r == IDX_W'(0));
      slot_r      <= (slot_r == IDX_W'(NVOICES - 1)) ? IDX_W'(0) : slot_r + IDX_W'(1);
    end else begin
      slot_r      <= slot_r;
    end
  end

endmodule

// File: tb/tb_voice_allocator_p.sv
// Randomized bench for voice_allocator_p with an in-bench note-table model and per-cycle output comparison.
module tb_voice_allocator_p;

  localparam int NV = 10;

  logic        clk, reset, clk_en, i_cmd_valid;
  logic [15:0] i_data;
  logic [6:0]  o_midi;
  logic [7:0]  o_velocity;
  logic [3:0]  o_voice_idx;
  logic        o_valid, o_frame, o_steal;
  logic [3:0]  o_wave_sel, o_active;

  voice_allocator_p dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .i_cmd_valid(i_cmd_valid), .i_data(i_data),
    .o_midi(o_midi), .o_velocity(o_velocity), .o_voice_idx(o_voice_idx), .o_valid(o_valid),
    .o_frame(o_frame), .o_wave_sel(o_wave_sel), .o_active(o_active), .o_steal(o_steal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // model state: the note table as the rules describe it
  int m_midi [NV];
  int m_vel  [NV];
  int m_age  [NV];
  int m_wave, m_slot;
  int exp_midi, exp_vel, exp_idx, exp_valid, exp_frame, exp_active, exp_steal, exp_wave;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] mk(input bit c, input int m, input int v);
    logic [6:0] mm;
    logic [7:0] vv;
    mm = 7'(m);
    vv = 8'(v);
    return {c, mm, vv};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_midi[i] = 0; m_vel[i] = 0; m_age[i] = 0;
    end
    m_wave = 0; m_slot = 0;
    exp_midi = 0; exp_vel = 0; exp_idx = 0; exp_valid = 0; exp_frame = 0;
    exp_active = 0; exp_steal = 0; exp_wave = 1;
  endtask

  task automatic model_cmd(input logic [15:0] d, output int stole);
    int c, m, v, slot, best;
    c = int'(d[15]); m = int'(d[14:8]); v = int'(d[7:0]);
    stole = 0;
    slot = -1;
    if (c == 1) begin
      if (m == 0) begin
        if (v == 0) m_wave = (m_wave + 1) % 4;
        return;
      end
      for (int i = 0; i < NV; i++) if (slot < 0 && m_midi[i] == m) slot = i;
      for (int i = 0; i < NV; i++) if (slot < 0 && m_midi[i] == 0) slot = i;
      if (slot < 0) begin
        best = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[best]) best = i;
        slot = best;
        stole = 1;
      end
      for (int i = 0; i < NV; i++)
        if (i != slot && m_midi[i] != 0) m_age[i] = (m_age[i] >= 63) ? 63 : m_age[i] + 1;
      m_midi[slot] = m; m_vel[slot] = v; m_age[slot] = 0;
    end else if (m == 127) begin
      for (int i = 0; i < NV; i++) begin
        m_midi[i] = 0; m_vel[i] = 0; m_age[i] = 0;
      end
    end else if (m != 0) begin
      for (int i = 0; i < NV; i++) if (slot < 0 && m_midi[i] == m) slot = i;
      if (slot >= 0) begin
        m_midi[slot] = 0; m_vel[slot] = 0; m_age[slot] = 0;
      end
    end
  endtask

  task automatic model_tick(input bit en, input bit cv, input logic [15:0] d);
    int stole, cnt;
    stole = 0;
    if (en) begin
      exp_midi  = m_midi[m_slot];
      exp_vel   = m_vel[m_slot];
      exp_idx   = m_slot;
      exp_valid = (m_midi[m_slot] != 0);
      exp_frame = (m_slot == 0);
      m_slot    = (m_slot + 1) % NV;
    end
    if (cv) model_cmd(d, stole);
    cnt = 0;
    for (int i = 0; i < NV; i++) if (m_midi[i] != 0) cnt++;
    exp_active = cnt;
    exp_steal  = stole;
    exp_wave   = 1 << m_wave;
  endtask

  task automatic step(input bit en, input bit cv, input logic [15:0] d);
    @(negedge clk);
    clk_en = en; i_cmd_valid = cv; i_data = d;
    @(posedge clk);
    model_tick(en, cv, d);
    #1;
  endtask

  task automatic dispatch_to(input int s);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 2 * NV && !hit; k++) begin
      step(1'b1, 1'b0, 16'h0000);
      hit = (exp_idx == s);
    end
    check("dispatch_reach", 32'(hit), 32'd1);
  endtask

  // compare DUT outputs with the model on every falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("o_midi",      32'(o_midi),      32'(exp_midi));
      check("o_velocity",  32'(o_velocity),  32'(exp_vel));
      check("o_voice_idx", 32'(o_voice_idx), 32'(exp_idx));
      check("o_valid",     32'(o_valid),     32'(exp_valid));
      check("o_frame",     32'(o_frame),     32'(exp_frame));
      check("o_active",    32'(o_active),    32'(exp_active));
      check("o_steal",     32'(o_steal),     32'(exp_steal));
      check("o_wave_sel",  32'(o_wave_sel),  32'(exp_wave));
    end
  end

  initial begin
    int r, frames;
    logic [3:0] waves [5];
    bit en, cv;
    logic [15:0] d;
    reset = 1'b1; clk_en = 1'b0; i_cmd_valid = 1'b0; i_data = 16'h0000;
    model_reset();
    #12;
    check("rst_wave", 32'(o_wave_sel), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_active", 32'(o_active), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;

    // 1: idle dispatch, clk_en every 4 clocks
    frames = 0;
    for (int i = 0; i < 80; i++) begin
      step(i % 4 == 0, 1'b0, 16'h0000);
      if (i % 4 == 0 && o_frame) frames++;
    end
    check("t1_frames", 32'(frames), 32'd2);
    check("t1_wave", 32'(o_wave_sel), 32'd1);

    // 2: two notes into slots 0 and 1
    step(1'b0, 1'b1, mk(1, 60, 100));
    step(1'b0, 1'b1, mk(1, 64, 80));
    check("t2_active", 32'(o_active), 32'd2);
    dispatch_to(0);
    check("t2_s0_midi", 32'(o_midi), 32'd60);
    check("t2_s0_vel", 32'(o_velocity), 32'd100);
    dispatch_to(1);
    check("t2_s1_midi", 32'(o_midi), 32'd64);
    check("t2_s1_vel", 32'(o_velocity), 32'd80);

    // 3: retrigger keeps a single slot
    step(1'b0, 1'b1, mk(0, 127, 0));
    step(1'b0, 1'b1, mk(1, 60, 100));
    step(1'b0, 1'b1, mk(1, 60, 20));
    check("t3_active", 32'(o_active), 32'd1);
    dispatch_to(0);
    check("t3_vel", 32'(o_velocity), 32'd20);
    dispatch_to(1);
    check("t3_s1_valid", 32'(o_valid), 32'd0);

    // 4: full table steals the oldest slot
    step(1'b0, 1'b1, mk(0, 127, 0));
    for (int n = 40; n < 50; n++) step(1'b0, 1'b1, mk(1, n, n));
    step(1'b0, 1'b1, mk(1, 70, 7));
    check("t4_steal", 32'(o_steal), 32'd1);
    step(1'b0, 1'b0, 16'h0000);
    check("t4_steal_pulse", 32'(o_steal), 32'd0);
    dispatch_to(0);
    check("t4_s0_midi", 32'(o_midi), 32'd70);
    dispatch_to(1);
    check("t4_s1_midi", 32'(o_midi), 32'd41);

    // 5: note-off, absent note-off, stop-all
    step(1'b0, 1'b1, mk(0, 45, 0));
    dispatch_to(5);
    check("t5_s5_valid", 32'(o_valid), 32'd0);
    step(1'b0, 1'b1, mk(0, 99, 0));
    check("t5_active", 32'(o_active), 32'd9);
    step(1'b0, 1'b1, mk(0, 127, 0));
    check("t5_stop_active", 32'(o_active), 32'd0);
    dispatch_to(3);
    check("t5_s3_valid", 32'(o_valid), 32'd0);

    // 6: waveform rotation and same-slot command/dispatch coincidence
    waves[0] = 4'b0010; waves[1] = 4'b0100; waves[2] = 4'b1000; waves[3] = 4'b0001; waves[4] = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, mk(1, 0, 0));
      check("t6_wave", 32'(o_wave_sel), 32'(waves[k]));
    end
    dispatch_to(9);
    step(1'b1, 1'b1, mk(1, 55, 33));
    check("t6_same_idx", 32'(o_voice_idx), 32'd0);
    check("t6_same_old", 32'(o_valid), 32'd0);
    dispatch_to(0);
    check("t6_same_new", 32'(o_midi), 32'd55);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = $urandom_range(0, 99);
      en = ($urandom_range(0, 2) == 0);
      cv = ($urandom_range(0, 1) == 1);
      if (r < 3)       d = mk(0, 127, 0);
      else if (r < 9)  d = mk(1, 0, 0);
      else if (r < 12) d = mk(1, 0, $urandom_range(1, 255));
      else if (r < 60) d = mk(1, $urandom_range(30, 45), $urandom_range(0, 255));
      else             d = mk(0, $urandom_range(30, 45), $urandom_range(0, 255));
      step(en, cv, d);
    end

    // async reset in the middle of a frame
    step(1'b0, 1'b1, mk(1, 50, 9));
    dispatch_to(4);
    @(negedge clk);
    clk_en = 1'b0; i_cmd_valid = 1'b0; i_data = 16'h0000;
    #2;
    reset = 1'b1;
    chk_on = 1'b0;
    model_reset();
    #1;
    check("mid_rst_midi", 32'(o_midi), 32'd0);
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_idx", 32'(o_voice_idx), 32'd0);
    check("mid_rst_wave", 32'(o_wave_sel), 32'd1);
    check("mid_rst_active", 32'(o_active), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    step(1'b1, 1'b0, 16'h0000);
    check("post_rst_idx", 32'(o_voice_idx), 32'd0);
    check("post_rst_frame", 32'(o_frame), 32'd1);
    step(1'b0, 1'b0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
